// File: rtl/segment_register_bank_if.sv
// Bus between the execution/microcode unit (master) and the segment register
// bank (slave): write/snapshot/restore controls, the read port and the flat register view.
interface segment_register_bank_if #(
    parameter int NUM_REGS = 4,
    parameter int WIDTH    = 16
);
    localparam int IDW = $clog2(NUM_REGS);

    logic                      we;
    logic [IDW-1:0]            write_id;
    logic [WIDTH-1:0]          write_data;
    logic [WIDTH/8-1:0]        byte_en;
    logic [IDW-1:0]            rd_id;
    logic [WIDTH-1:0]          rd_data;
    logic                      snapshot;
    logic                      restore;
    logic                      snap_valid;
    logic                      instr_done;
    logic                      irq_inhibit;
    logic [NUM_REGS*WIDTH-1:0] registers;

    modport master (
        output we, write_id, write_data, byte_en, rd_id, snapshot, restore, instr_done,
        input  rd_data, snap_valid, irq_inhibit, registers
    );
    modport slave (
        input  we, write_id, write_data, byte_en, rd_id, snapshot, restore, instr_done,
        output rd_data, snap_valid, irq_inhibit, registers
    );
endinterface

// File: rtl/segment_register_bank.sv
// Parametrised segment register file with byte-lane writes, read bypass,
// a one-deep snapshot/restore shadow bank and a post-SS-write interrupt-inhibit window.
module segment_register_bank #(
    parameter int               NUM_REGS     = 4,
    parameter int               WIDTH        = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE0 = WIDTH'(16'hFFFF),
    parameter int               INHIBIT_ID   = 2,
    parameter int               INHIBIT_LEN  = 1
) (
    input logic                    clk,
    input logic                    reset_n,
    segment_register_bank_if.slave bus
);
    localparam int IDW = $clog2(NUM_REGS);
    localparam int NB  = WIDTH / 8;

    if ((WIDTH % 8) != 0 || WIDTH < 8) begin : g_bad_width
        $error("segment_register_bank: WIDTH must be a nonzero multiple of 8");
    end
    if (NUM_REGS < 2) begin : g_bad_count
        $error("segment_register_bank: NUM_REGS must be at least 2");
    end
    if (INHIBIT_LEN < 1 || INHIBIT_LEN > 7 || INHIBIT_ID < 0 || INHIBIT_ID >= NUM_REGS) begin : g_bad_inh
        $error("segment_register_bank: INHIBIT_ID/INHIBIT_LEN out of range");
    end

    logic [NUM_REGS-1:0][WIDTH-1:0] live_q, live_d, shadow_q, shadow_d;
    logic                           snap_valid_q, snap_valid_d;
    logic [2:0]                     inh_q, inh_d;
    logic                           irq_q, irq_d;

    logic [WIDTH-1:0] lane_mask, rd_live, rd_data;
    logic             restore_eff, wr_eff, wr_inh, rd_hit;

    always_comb begin
        lane_mask = '0;
        for (int b = 0; b < NB; b++) lane_mask[8*b +: 8] = {8{bus.byte_en[b]}};

        restore_eff = bus.restore && snap_valid_q;
        wr_eff      = bus.we && !restore_eff;
        wr_inh      = wr_eff && (bus.write_id == IDW'(INHIBIT_ID)) && (|bus.byte_en);

        // Out-of-range read ids match no entry and fall through to zero.
        rd_live = '0;
        rd_hit  = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (bus.rd_id == IDW'(r)) begin
                rd_live = live_q[r];
                rd_hit  = 1'b1;
            end
        end
        rd_data = rd_live;
        if (wr_eff && rd_hit && (bus.write_id == bus.rd_id))
            rd_data = (bus.write_data & lane_mask) | (rd_live & ~lane_mask);

        live_d = live_q;
        if (restore_eff) begin
            live_d = shadow_q;
        end else if (bus.we) begin
            for (int r = 0; r < NUM_REGS; r++)
                if (bus.write_id == IDW'(r))
                    live_d[r] = (bus.write_data & lane_mask) | (live_q[r] & ~lane_mask);
        end

        // Snapshot captures pre-edge live values, so a same-cycle write is not in it.
        shadow_d     = (bus.snapshot && !restore_eff) ? live_q : shadow_q;
        snap_valid_d = restore_eff ? 1'b0 : (bus.snapshot ? 1'b1 : snap_valid_q);

        inh_d = inh_q;
        if (restore_eff)                        inh_d = '0;
        else if (wr_inh)                        inh_d = 3'(INHIBIT_LEN);
        else if (bus.instr_done && inh_q != '0) inh_d = inh_q - 3'd1;
        irq_d = (inh_d != '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            live_q       <= '0;
            live_q[0]    <= RESET_VALUE0;
            shadow_q     <= '0;
            shadow_q[0]  <= RESET_VALUE0;
            snap_valid_q <= 1'b0;
            inh_q        <= '0;
            irq_q        <= 1'b0;
        end else begin
            live_q       <= live_d;
            shadow_q     <= shadow_d;
            snap_valid_q <= snap_valid_d;
            inh_q        <= inh_d;
            irq_q        <= irq_d;
        end
    end

    assign bus.rd_data     = rd_data;
    assign bus.snap_valid  = snap_valid_q;
    assign bus.irq_inhibit = irq_q;
    assign bus.registers   = live_q;
endmodule

// File: tb/tb_segment_register_bank.sv
// Scoreboard bench: the driver queues expected values tagged with the cycle
// they are due; a negedge monitor pops and compares against the DUT outputs.
module tb_segment_register_bank;
    logic clk;
    logic reset_n;
    int   cyc;
    int   checks;
    int   errors;

    segment_register_bank_if #(.NUM_REGS(4), .WIDTH(16)) ifa ();
    segment_register_bank_if #(.NUM_REGS(6), .WIDTH(32)) ifb ();

    segment_register_bank #(.NUM_REGS(4), .WIDTH(16)) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(ifa.slave)
    );
    segment_register_bank #(.NUM_REGS(6), .WIDTH(32), .RESET_VALUE0(32'hDEAD_BEEF)) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(ifb.slave)
    );

    typedef struct {
        int           cyc;
        int           dut;
        int           sel;   // 0 rd_data, 1 registers, 2 snap_valid, 3 irq_inhibit
        logic [191:0] exp;
        string        name;
    } exp_t;

    exp_t sb[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_val(input int c, input int d, input int s, input logic [191:0] v, input string n);
        exp_t e;
        e.cyc = c; e.dut = d; e.sel = s; e.exp = v; e.name = n;
        sb.push_back(e);
    endtask

    exp_t         me;
    logic [191:0] act;
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            me  = sb.pop_front();
            act = '0;
            if (me.dut == 0) begin
                case (me.sel)
                    0: act = 192'(ifa.rd_data);
                    1: act = 192'(ifa.registers);
                    2: act = 192'(ifa.snap_valid);
                    default: act = 192'(ifa.irq_inhibit);
                endcase
            end else begin
                case (me.sel)
                    0: act = 192'(ifb.rd_data);
                    1: act = 192'(ifb.registers);
                    2: act = 192'(ifb.snap_valid);
                    default: act = 192'(ifb.irq_inhibit);
                endcase
            end
            checks++;
            if (act !== me.exp) begin
                errors++;
                $display("FAIL %s: got %0h expected %0h (cycle %0d)", me.name, act, me.exp, cyc);
            end
        end
    end

    task automatic clear_all();
        ifa.we = 0; ifa.write_id = '0; ifa.write_data = '0; ifa.byte_en = '0; ifa.rd_id = '0;
        ifa.snapshot = 0; ifa.restore = 0; ifa.instr_done = 0;
        ifb.we = 0; ifb.write_id = '0; ifb.write_data = '0; ifb.byte_en = '0; ifb.rd_id = '0;
        ifb.snapshot = 0; ifb.restore = 0; ifb.instr_done = 0;
    endtask

    // Advance to just after the next rising edge with all pulses cleared.
    task automatic step();
        @(posedge clk);
        #1;
        clear_all();
    endtask

    task automatic wr_a(input logic [1:0] id, input logic [1:0] be, input logic [15:0] d);
        ifa.we = 1; ifa.write_id = id; ifa.byte_en = be; ifa.write_data = d;
    endtask

    localparam logic [191:0] B_RST = {160'h0, 32'hDEAD_BEEF};

    initial begin
        cyc = 0; checks = 0; errors = 0;
        reset_n = 1'b0;
        clear_all();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        ifb.rd_id = 3'd6;
        expect_val(cyc, 0, 1, {16'h0, 16'h0, 16'h0, 16'hFFFF}, "reset_regs_a");
        expect_val(cyc, 0, 2, 0, "reset_snap_a");
        expect_val(cyc, 0, 3, 0, "reset_irq_a");
        expect_val(cyc, 0, 0, 16'hFFFF, "reset_rd0_a");
        expect_val(cyc, 1, 1, B_RST, "reset_regs_b");
        expect_val(cyc, 1, 0, 0, "rd_oor_b");

        step(); wr_a(2'd1, 2'b11, 16'h1234);
        expect_val(cyc + 1, 0, 1, {16'h0, 16'h0, 16'h1234, 16'hFFFF}, "write_full_a");
        expect_val(cyc + 1, 0, 3, 0, "no_inh_reg1");

        step(); wr_a(2'd1, 2'b10, 16'hAB00); ifa.rd_id = 2'd1;
        expect_val(cyc, 0, 0, 16'hAB34, "bypass_merge");
        expect_val(cyc + 1, 0, 1, {16'h0, 16'h0, 16'hAB34, 16'hFFFF}, "byte_write");

        step(); wr_a(2'd1, 2'b01, 16'h00CD); ifa.rd_id = 2'd0;
        expect_val(cyc, 0, 0, 16'hFFFF, "no_bypass_other_id");
        ifa.we = 0;

        step(); wr_a(2'd3, 2'b11, 16'h0040);
        expect_val(cyc + 1, 0, 1, {16'h0040, 16'h0, 16'hAB34, 16'hFFFF}, "write_reg3");

        step(); wr_a(2'd3, 2'b11, 16'h0050); ifa.snapshot = 1;
        expect_val(cyc + 1, 0, 1, {16'h0050, 16'h0, 16'hAB34, 16'hFFFF}, "snap_same_write");
        expect_val(cyc + 1, 0, 2, 1, "snap_valid_set");

        step(); ifa.restore = 1;
        expect_val(cyc + 1, 0, 1, {16'h0040, 16'h0, 16'hAB34, 16'hFFFF}, "restore_regs");
        expect_val(cyc + 1, 0, 2, 0, "restore_clears_valid");

        step(); ifa.restore = 1;
        expect_val(cyc + 1, 0, 1, {16'h0040, 16'h0, 16'hAB34, 16'hFFFF}, "restore_noop");
        expect_val(cyc + 1, 0, 2, 0, "restore_noop_valid");

        step(); ifa.snapshot = 1;
        expect_val(cyc + 1, 0, 2, 1, "resnap_valid");

        step(); wr_a(2'd0, 2'b11, 16'h1111);
        expect_val(cyc + 1, 0, 1, {16'h0040, 16'h0, 16'hAB34, 16'h1111}, "write_reg0");

        step(); wr_a(2'd2, 2'b11, 16'h7777); ifa.restore = 1; ifa.snapshot = 1; ifa.rd_id = 2'd2;
        expect_val(cyc, 0, 0, 16'h0000, "no_bypass_on_restore");
        expect_val(cyc + 1, 0, 1, {16'h0040, 16'h0, 16'hAB34, 16'hFFFF}, "restore_priority");
        expect_val(cyc + 1, 0, 2, 0, "restore_priority_valid");
        expect_val(cyc + 1, 0, 3, 0, "dropped_write_no_inh");

        step();
        expect_val(cyc + 1, 0, 2, 0, "snapshot_ignored");

        step(); wr_a(2'd2, 2'b11, 16'h0022);
        expect_val(cyc + 1, 0, 3, 1, "inh_open");
        expect_val(cyc + 1, 0, 1, {16'h0040, 16'h0022, 16'hAB34, 16'hFFFF}, "write_reg2");

        step(); ifa.instr_done = 1;
        expect_val(cyc + 1, 0, 3, 0, "inh_close");

        step(); wr_a(2'd2, 2'b01, 16'h0033);
        expect_val(cyc + 1, 0, 3, 1, "inh_open_partial");
        expect_val(cyc + 1, 0, 1, {16'h0040, 16'h0033, 16'hAB34, 16'hFFFF}, "write_reg2_lane0");

        step(); wr_a(2'd2, 2'b11, 16'h0044); ifa.instr_done = 1;
        expect_val(cyc + 1, 0, 3, 1, "inh_load_wins");

        step(); ifa.instr_done = 1;
        expect_val(cyc + 1, 0, 3, 0, "inh_close2");

        step(); wr_a(2'd2, 2'b00, 16'hFFFF);
        expect_val(cyc + 1, 0, 3, 0, "no_inh_be0");
        expect_val(cyc + 1, 0, 1, {16'h0040, 16'h0044, 16'hAB34, 16'hFFFF}, "be0_no_change");

        step(); ifb.we = 1; ifb.write_id = 3'd7; ifb.byte_en = 4'hF; ifb.write_data = 32'h1234_5678;
        expect_val(cyc + 1, 1, 1, B_RST, "oor_write_b");

        step(); ifb.we = 1; ifb.write_id = 3'd6; ifb.byte_en = 4'hF; ifb.write_data = 32'h1234_5678;
        ifb.rd_id = 3'd6;
        expect_val(cyc, 1, 0, 0, "oor_rd_bypass_b");

        step(); ifb.we = 1; ifb.write_id = 3'd5; ifb.byte_en = 4'b1100; ifb.write_data = 32'hCAFE_1234;
        ifb.rd_id = 3'd5;
        expect_val(cyc, 1, 0, 32'hCAFE_0000, "bypass_b");
        expect_val(cyc + 1, 1, 1, {32'hCAFE_0000, 128'h0, 32'hDEAD_BEEF}, "write_reg5_b");

        step(); wr_a(2'd2, 2'b11, 16'h0055); ifa.snapshot = 1;
        expect_val(cyc + 1, 0, 3, 1, "pre_reset_inh");
        expect_val(cyc + 1, 0, 2, 1, "pre_reset_snap");

        step();
        step(); reset_n = 1'b0;
        expect_val(cyc, 0, 1, {16'h0, 16'h0, 16'h0, 16'hFFFF}, "async_reset_regs_a");
        expect_val(cyc, 0, 2, 0, "async_reset_snap");
        expect_val(cyc, 0, 3, 0, "async_reset_irq");
        expect_val(cyc, 1, 1, B_RST, "async_reset_regs_b");

        step(); reset_n = 1'b1;
        step();
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            $display("FAIL drain: %0d checks pending expected 0", sb.size());
            checks += sb.size();
            errors += sb.size();
        end
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/segment_register_bank.md
Name: segment_register_bank

Overview:
- Parametrised segment register bank for the V30MZ core. Generalises the fixed 4x16 segment file: configurable count/width, byte-lane writes, same-cycle read bypass, one-deep snapshot/restore shadow bank for fault rollback, interrupt-inhibit window after a stack-segment write.
- Sits between the execution/microcode unit (writes, snapshot/restore, instruction boundaries) and the address generator (reads, flat register bus).

Parameters:
- NUM_REGS, 4, number of segment registers (>=2).
- WIDTH, 16, register width in bits; must be a multiple of 8, elaboration error otherwise.
- RESET_VALUE0, 16'hFFFF, reset value of register 0 (CS); all other registers reset to 0.
- INHIBIT_ID, 2, index of the register whose write opens the interrupt-inhibit window (SS).
- INHIBIT_LEN, 1, number of instruction boundaries the inhibit window lasts (1..7).

Ports:
- clk  input  1  clock, all state updates on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- we  input  1  write enable.
- write_id  input  $clog2(NUM_REGS)  write register index.
- write_data  input  WIDTH  write data.
- byte_en  input  WIDTH/8  per-byte write lane enable; bit i covers bits [8i+7:8i].
- rd_id  input  $clog2(NUM_REGS)  read port index.
- rd_data  output  WIDTH  combinational read with write bypass.
- snapshot  input  1  copy live registers into shadow bank.
- restore  input  1  copy shadow bank back into live registers.
- snap_valid  output  1  shadow bank holds an unconsumed snapshot.
- instr_done  input  1  one-cycle pulse at each instruction boundary.
- irq_inhibit  output  1  high while the inhibit window is open.
- registers  output  NUM_REGS*WIDTH  flat bus of live registers; register i at [i*WIDTH +: WIDTH].

Behaviour:
- Reset (reset_n low, asynchronous, immediate): live[0]=RESET_VALUE0, live[1..]=0; shadow identical; snap_valid=0; inhibit counter=0 so irq_inhibit=0. Reset mid-window or mid-snapshot discards all state.
- Write: on posedge with we=1 and write_id<NUM_REGS, live[write_id] lanes with byte_en=1 take write_data; other lanes hold. write_id>=NUM_REGS or byte_en=0 means no register change. Visible on registers one cycle after the edge.
- rd_data: combinational. If we=1, write_id==rd_id, and restore is not taking effect, return merged value (enabled lanes from write_data, others from live). Otherwise live[rd_id]. rd_id>=NUM_REGS returns 0.
- Snapshot: on posedge with snapshot=1, shadow takes pre-edge live values (a same-cycle write is NOT captured); snap_valid<=1. Re-snapshot overwrites.
- Restore: on posedge with restore=1 and snap_valid=1: live<=shadow, snap_valid<=0, inhibit counter<=0. Restore overrides any same-cycle we (write dropped) and any same-cycle snapshot (ignored). restore with snap_valid=0 is a no-op; we and snapshot then proceed normally.
- Inhibit counter (3 bits): an effective write to INHIBIT_ID (any byte_en nonzero, not overridden by restore) loads INHIBIT_LEN. Otherwise instr_done=1 with counter>0 decrements by 1. Load wins over a same-cycle instr_done. Counter saturates at 0. irq_inhibit = (counter!=0), registered, 0 at reset.
- No other latency. All outputs except rd_data are registered.

Test Plan:
- Reset: release reset_n -> registers = {0,0,0,16'hFFFF} (reg3..reg0), snap_valid=0, irq_inhibit=0; assert reset_n low mid-operation -> same values immediately, without waiting for a clock edge.
- Byte write + bypass: live[1]=16'h1234; we, write_id=1, byte_en=2'b10, write_data=16'hAB00, rd_id=1 -> rd_data=16'hAB34 in the same cycle, registers[31:16]=16'hAB34 after the edge.
- Snapshot/restore: live[3]=16'h0040; snapshot with a same-cycle write of 16'h0050 to reg3 -> reg3=16'h0050, snap_valid=1; restore -> reg3=16'h0040, snap_valid=0; second restore -> no change.
- Restore priority: restore, snapshot, and we (reg2=16'h7777) in the same cycle with snap_valid=1 -> shadow values restored, write dropped, snap_valid=0.
- Inhibit window (INHIBIT_LEN=1): write reg2 -> irq_inhibit=1 next cycle; instr_done pulse -> irq_inhibit=0 after that edge; write reg2 together with instr_done -> irq_inhibit stays 1.
- Out-of-range and parameter sweep: NUM_REGS=6, WIDTH=32; write_id=7 -> no register change; rd_id=6 -> rd_data=0; reset value of reg0 = RESET_VALUE0.
